// File: rtl/register_file_mp.sv
// register_file_mp
//   Multi-ported register file with a per-register busy scoreboard.
//   NRD combinational read ports and NWR synchronous write ports. Optional
//   same-cycle write-to-read bypass and an optional hard-wired zero register.
//   The busy bits mark registers that have an issued but not yet written-back
//   producer. The issue stage uses them to detect RAW hazards.
//
// Ports
//   CLK        clock; all state updates on the rising edge
//   RST        synchronous active-high reset (clears data, busy, wconflict)
//   rsel       read selects, port i at [i*AW +: AW]
//   rdat       read data, port i at [i*DATA_W +: DATA_W]
//   rbusy      busy flag of the register selected on each read port
//   wen        write enables, one per write port
//   wsel       write selects, port k at [k*AW +: AW]
//   wdat       write data, port k at [k*DATA_W +: DATA_W]
//   iss_en     issue strobe: mark iss_sel as having a pending write
//   iss_sel    destination register of the issued instruction
//   wconflict  one-cycle pulse: two or more write ports hit the same register
//              in the previous cycle
module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [NRD*$clog2(NREGS)-1:0]      rsel,
  output logic [NRD*DATA_W-1:0]             rdat,
  output logic [NRD-1:0]                    rbusy,
  input  logic [NWR-1:0]                    wen,
  input  logic [NWR*$clog2(NREGS)-1:0]      wsel,
  input  logic [NWR*DATA_W-1:0]             wdat,
  input  logic                              iss_en,
  input  logic [$clog2(NREGS)-1:0]          iss_sel,
  output logic                              wconflict
);

  localparam int AW = $clog2(NREGS);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  r_busy;
  logic              r_wconflict;

  logic [NREGS-1:0]  w_wr_hit;
  logic [DATA_W-1:0] w_wr_data [NREGS];
  logic [NREGS-1:0]  w_busy_nxt;
  logic              w_conflict;

  function automatic logic is_zero_reg(input logic [AW-1:0] sel);
    return (ZERO_REG != 0) && (sel == '0);
  endfunction

  // Per-register write resolution; scanning ports upward lets the
  // highest-index port win a collision.
  always_comb begin
    w_wr_hit = '0;
    for (int r = 0; r < NREGS; r++) begin
      w_wr_data[r] = '0;
      for (int k = 0; k < NWR; k++) begin
        if (wen[k] && (wsel[k*AW +: AW] == AW'(r)) && !is_zero_reg(AW'(r))) begin
          w_wr_hit[r]  = 1'b1;
          w_wr_data[r] = wdat[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Issue beats writeback: a fresh producer keeps the register busy even
  // though the older result lands this cycle.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int r = 0; r < NREGS; r++) begin
      if (iss_en && (iss_sel == AW'(r)) && !is_zero_reg(AW'(r))) begin
        w_busy_nxt[r] = 1'b1;
      end else if (w_wr_hit[r]) begin
        w_busy_nxt[r] = 1'b0;
      end
    end
  end

  always_comb begin
    w_conflict = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      for (int k = j + 1; k < NWR; k++) begin
        if (wen[j] && wen[k] && (wsel[j*AW +: AW] == wsel[k*AW +: AW]) &&
            !is_zero_reg(wsel[j*AW +: AW])) begin
          w_conflict = 1'b1;
        end
      end
    end
  end

  // Read ports: stored value, optionally overridden by a same-cycle write
  // (highest port wins, data counts as available so busy drops), and the
  // zero register overrides everything.
  always_comb begin
    logic [AW-1:0] v_sel;
    v_sel = '0;
    rdat  = '0;
    rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      v_sel = rsel[i*AW +: AW];
      rdat[i*DATA_W +: DATA_W] = r_regs[v_sel];
      rbusy[i]                 = r_busy[v_sel];
      if (BYPASS != 0) begin
        for (int k = 0; k < NWR; k++) begin
          if (wen[k] && (wsel[k*AW +: AW] == v_sel)) begin
            rdat[i*DATA_W +: DATA_W] = wdat[k*DATA_W +: DATA_W];
            rbusy[i]                 = 1'b0;
          end
        end
      end
      if (is_zero_reg(v_sel)) begin
        rdat[i*DATA_W +: DATA_W] = '0;
        rbusy[i]                 = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int r = 0; r < NREGS; r++) begin
        r_regs[r] <= '0;
      end
      r_busy      <= '0;
      r_wconflict <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (w_wr_hit[r]) begin
          r_regs[r] <= w_wr_data[r];
        end
      end
      r_busy      <= w_busy_nxt;
      r_wconflict <= w_conflict;
    end
  end

  assign wconflict = r_wconflict;

endmodule

// File: tb/tb_register_file_mp.sv
// Testbench for register_file_mp. Two instances run side by side:
//   inst0: defaults (32x32, 2R/2W, zero register, bypass)
//   inst1: 8x16, 4R/3W, no zero register, no bypass
// A driver issues stimulus shortly after each rising edge. It pushes the
// expected outputs for that cycle from a behavioural model. A monitor pops
// and compares at the falling edge.
module tb_register_file_mp;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        a_rst, a_iss_en, a_wc;
  logic [9:0]  a_rsel, a_wsel;
  logic [63:0] a_rdat, a_wdat;
  logic [1:0]  a_rbusy, a_wen;
  logic [4:0]  a_iss_sel;

  logic        b_rst, b_iss_en, b_wc;
  logic [11:0] b_rsel;
  logic [63:0] b_rdat;
  logic [3:0]  b_rbusy;
  logic [2:0]  b_wen, b_iss_sel;
  logic [8:0]  b_wsel;
  logic [47:0] b_wdat;

  register_file_mp u_a (
    .CLK(CLK), .RST(a_rst), .rsel(a_rsel), .rdat(a_rdat), .rbusy(a_rbusy),
    .wen(a_wen), .wsel(a_wsel), .wdat(a_wdat), .iss_en(a_iss_en),
    .iss_sel(a_iss_sel), .wconflict(a_wc)
  );

  register_file_mp #(
    .DATA_W(16), .NREGS(8), .NRD(4), .NWR(3), .ZERO_REG(0), .BYPASS(0)
  ) u_b (
    .CLK(CLK), .RST(b_rst), .rsel(b_rsel), .rdat(b_rdat), .rbusy(b_rbusy),
    .wen(b_wen), .wsel(b_wsel), .wdat(b_wdat), .iss_en(b_iss_en),
    .iss_sel(b_iss_sel), .wconflict(b_wc)
  );

  // Instance-independent stimulus, packed onto each instance below.
  logic        t_rst     [2];
  logic [4:0]  t_rsel    [2][4];
  logic        t_wen     [2][3];
  logic [4:0]  t_wsel    [2][3];
  logic [31:0] t_wdat    [2][3];
  logic        t_iss_en  [2];
  logic [4:0]  t_iss_sel [2];

  always_comb begin
    a_rst = t_rst[0]; a_iss_en = t_iss_en[0]; a_iss_sel = t_iss_sel[0];
    a_rsel = '0; a_wen = '0; a_wsel = '0; a_wdat = '0;
    for (int i = 0; i < 2; i++) a_rsel[i*5 +: 5] = t_rsel[0][i];
    for (int k = 0; k < 2; k++) begin
      a_wen[k] = t_wen[0][k]; a_wsel[k*5 +: 5] = t_wsel[0][k]; a_wdat[k*32 +: 32] = t_wdat[0][k];
    end
    b_rst = t_rst[1]; b_iss_en = t_iss_en[1]; b_iss_sel = t_iss_sel[1][2:0];
    b_rsel = '0; b_wen = '0; b_wsel = '0; b_wdat = '0;
    for (int i = 0; i < 4; i++) b_rsel[i*3 +: 3] = t_rsel[1][i][2:0];
    for (int k = 0; k < 3; k++) begin
      b_wen[k] = t_wen[1][k]; b_wsel[k*3 +: 3] = t_wsel[1][k][2:0]; b_wdat[k*16 +: 16] = t_wdat[1][k][15:0];
    end
  end

  logic [31:0] act_rd [2][4];
  logic        act_rb [2][4];
  logic        act_wc [2];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      act_rd[0][i] = '0; act_rb[0][i] = 1'b0;
      act_rd[1][i] = {16'h0, b_rdat[i*16 +: 16]}; act_rb[1][i] = b_rbusy[i];
    end
    for (int i = 0; i < 2; i++) begin
      act_rd[0][i] = a_rdat[i*32 +: 32]; act_rb[0][i] = a_rbusy[i];
    end
    act_wc[0] = a_wc; act_wc[1] = b_wc;
  end

  function automatic int nr(input int d);  return (d == 0) ? 32 : 8; endfunction
  function automatic int nrd(input int d); return (d == 0) ? 2 : 4;  endfunction
  function automatic int nwr(input int d); return (d == 0) ? 2 : 3;  endfunction
  function automatic bit zr(input int d);  return d == 0; endfunction
  function automatic bit bp(input int d);  return d == 0; endfunction
  function automatic logic [31:0] dmask(input int d);
    return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  // Reference model state: what each DUT holds after the latest edge.
  logic [31:0] m_regs [2][32];
  logic        m_busy [2][32];
  logic        m_conf [2];

  typedef struct packed {
    logic [3:0][31:0] rd;
    logic [3:0]       rb;
    logic             wc;
    int               cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t mon_e;
  int   n_checks, n_errs, cyc;

  task automatic compare(input int d, input exp_t e);
    for (int i = 0; i < nrd(d); i++) begin
      n_checks++;
      if (act_rd[d][i] !== e.rd[i]) begin
        n_errs++;
        $display("FAIL rdat inst%0d port%0d cyc%0d: got %h expected %h", d, i, e.cyc, act_rd[d][i], e.rd[i]);
      end
      n_checks++;
      if (act_rb[d][i] !== e.rb[i]) begin
        n_errs++;
        $display("FAIL rbusy inst%0d port%0d cyc%0d: got %b expected %b", d, i, e.cyc, act_rb[d][i], e.rb[i]);
      end
    end
    n_checks++;
    if (act_wc[d] !== e.wc) begin
      n_errs++;
      $display("FAIL wconflict inst%0d cyc%0d: got %b expected %b", d, e.cyc, act_wc[d], e.wc);
    end
  endtask

  always @(negedge CLK) begin
    if (q0.size() > 0) begin mon_e = q0.pop_front(); compare(0, mon_e); end
    if (q1.size() > 0) begin mon_e = q1.pop_front(); compare(1, mon_e); end
  end

  task automatic set_idle();
    for (int d = 0; d < 2; d++) begin
      t_rst[d] = 1'b0; t_iss_en[d] = 1'b0; t_iss_sel[d] = '0;
      for (int i = 0; i < 4; i++) t_rsel[d][i] = '0;
      for (int k = 0; k < 3; k++) begin
        t_wen[d][k] = 1'b0; t_wsel[d][k] = '0; t_wdat[d][k] = '0;
      end
    end
  endtask

  task automatic begin_cycle();
    @(posedge CLK);
    #1;
    cyc++;
    set_idle();
  endtask

  // Expected outputs for the current inputs, then the model's next state.
  task automatic end_cycle();
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      logic [4:0] s;
      e = '0;
      e.cyc = cyc;
      e.wc = m_conf[d];
      for (int i = 0; i < nrd(d); i++) begin
        s = t_rsel[d][i];
        e.rd[i] = m_regs[d][s];
        e.rb[i] = m_busy[d][s];
        if (bp(d)) begin
          for (int k = 0; k < nwr(d); k++)
            if (t_wen[d][k] && t_wsel[d][k] == s) begin
              e.rd[i] = t_wdat[d][k] & dmask(d);
              e.rb[i] = 1'b0;
            end
        end
        if (zr(d) && s == 0) begin
          e.rd[i] = '0; e.rb[i] = 1'b0;
        end
      end
      if (d == 0) q0.push_back(e); else q1.push_back(e);

      if (t_rst[d]) begin
        for (int r = 0; r < 32; r++) begin m_regs[d][r] = '0; m_busy[d][r] = 1'b0; end
        m_conf[d] = 1'b0;
      end else begin
        m_conf[d] = 1'b0;
        for (int j = 0; j < nwr(d); j++)
          for (int k = j + 1; k < nwr(d); k++)
            if (t_wen[d][j] && t_wen[d][k] && t_wsel[d][j] == t_wsel[d][k] &&
                !(zr(d) && t_wsel[d][j] == 0)) m_conf[d] = 1'b1;
        for (int k = 0; k < nwr(d); k++)
          if (t_wen[d][k] && !(zr(d) && t_wsel[d][k] == 0)) begin
            m_regs[d][t_wsel[d][k]] = t_wdat[d][k] & dmask(d);
            m_busy[d][t_wsel[d][k]] = 1'b0;
          end
        if (t_iss_en[d] && !(zr(d) && t_iss_sel[d] == 0)) m_busy[d][t_iss_sel[d]] = 1'b1;
      end
    end
  endtask

  task automatic wr(input int d, input int k, input int sel, input logic [31:0] dat);
    t_wen[d][k] = 1'b1; t_wsel[d][k] = 5'(sel); t_wdat[d][k] = dat;
  endtask
  task automatic rd(input int d, input int i, input int sel);
    t_rsel[d][i] = 5'(sel);
  endtask
  task automatic iss(input int d, input int sel);
    t_iss_en[d] = 1'b1; t_iss_sel[d] = 5'(sel);
  endtask

  task automatic random_cycle();
    begin_cycle();
    for (int d = 0; d < 2; d++) begin
      t_rst[d] = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < nwr(d); k++) begin
        t_wen[d][k]  = 1'($urandom_range(0, 1));
        t_wsel[d][k] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3))
                                                   : 5'($urandom_range(0, nr(d) - 1));
        t_wdat[d][k] = $urandom;
      end
      t_iss_en[d]  = ($urandom_range(0, 2) == 0);
      t_iss_sel[d] = 5'($urandom_range(0, nr(d) - 1));
      for (int i = 0; i < nrd(d); i++)
        t_rsel[d][i] = ($urandom_range(0, 1) == 0) ? t_wsel[d][$urandom_range(0, nwr(d) - 1)]
                                                   : 5'($urandom_range(0, nr(d) - 1));
    end
    end_cycle();
  endtask

  initial begin
    n_checks = 0; n_errs = 0; cyc = 0;
    set_idle();
    t_rst[0] = 1'b1; t_rst[1] = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 32; r++) begin m_regs[d][r] = '0; m_busy[d][r] = 1'b0; end
      m_conf[d] = 1'b0;
    end

    // Second reset cycle, then read back every register.
    begin_cycle(); t_rst[0] = 1'b1; t_rst[1] = 1'b1; end_cycle();
    for (int r = 0; r < 32; r += 2) begin
      begin_cycle();
      rd(0, 0, r); rd(0, 1, r + 1);
      for (int i = 0; i < 4; i++) rd(1, i, (r + i) % 8);
      end_cycle();
    end

    // Zero register ignores writes; inst1 register 0 is ordinary.
    begin_cycle(); wr(0, 0, 0, 32'hDEADBEEF); rd(0, 0, 0); wr(1, 0, 0, 32'h1234); rd(1, 0, 0); end_cycle();
    begin_cycle(); rd(0, 0, 0); rd(1, 0, 0); end_cycle();

    // Two ports, two registers; same-cycle read shows bypass vs stored.
    begin_cycle();
    wr(0, 0, 5, 32'h11111111); wr(0, 1, 9, 32'h22222222); rd(0, 0, 5); rd(0, 1, 9);
    wr(1, 0, 5, 32'h1111);     wr(1, 1, 6, 32'h2222);     rd(1, 0, 5); rd(1, 1, 6);
    end_cycle();
    begin_cycle(); rd(0, 0, 5); rd(0, 1, 9); rd(1, 0, 5); rd(1, 1, 6); end_cycle();

    // Write collision on reg7, then both ports on reg0.
    begin_cycle();
    wr(0, 0, 7, 32'hAAAA0000); wr(0, 1, 7, 32'h0000BBBB);
    wr(1, 0, 7, 32'hAAAA);     wr(1, 2, 7, 32'hBBBB);
    end_cycle();
    begin_cycle(); rd(0, 0, 7); rd(1, 0, 7); end_cycle();
    begin_cycle(); rd(0, 0, 7); wr(0, 0, 0, 32'h1); wr(0, 1, 0, 32'h2); wr(1, 1, 0, 32'h3); wr(1, 2, 0, 32'h4); end_cycle();
    begin_cycle(); rd(0, 0, 0); rd(1, 0, 0); end_cycle();
    begin_cycle(); end_cycle();

    // Scoreboard: issue, writeback, then issue racing a writeback.
    begin_cycle(); iss(0, 12); iss(1, 4); end_cycle();
    begin_cycle(); rd(0, 0, 12); rd(1, 0, 4); end_cycle();
    begin_cycle(); wr(0, 1, 12, 32'h5); rd(0, 0, 12); wr(1, 1, 4, 32'h5); rd(1, 0, 4); end_cycle();
    begin_cycle(); rd(0, 0, 12); rd(1, 0, 4); end_cycle();
    begin_cycle(); iss(0, 12); wr(0, 0, 12, 32'h6); rd(0, 1, 12); iss(1, 4); wr(1, 2, 4, 32'h6); end_cycle();
    begin_cycle(); rd(0, 0, 12); rd(1, 0, 4); end_cycle();

    // Reset lands on a pending write and busy register.
    begin_cycle(); iss(0, 3); iss(1, 3); end_cycle();
    begin_cycle();
    wr(0, 0, 3, 32'hFFFFFFFF); rd(0, 0, 3); t_rst[0] = 1'b1;
    wr(1, 0, 3, 32'hFFFF);     rd(1, 0, 3); t_rst[1] = 1'b1;
    end_cycle();
    begin_cycle(); rd(0, 0, 3); rd(0, 1, 12); rd(1, 0, 3); rd(1, 1, 4); end_cycle();

    for (int n = 0; n < 10000; n++) random_cycle();

    begin_cycle(); end_cycle();
    repeat (2) @(negedge CLK);
    n_checks++;
    if (q0.size() + q1.size() != 0) begin
      n_errs++;
      $display("FAIL drain: got %0d pending expected 0", q0.size() + q1.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-ported CPU register file with an integrated busy scoreboard. It is the successor to the single-write, dual-read register file.
- Provides NRD combinational read ports and NWR synchronous write ports, with optional same-cycle write-to-read bypass and an optional hard-wired zero register.
- Tracks per-register "pending write" busy bits so the issue stage can detect RAW hazards. Sits between decode/issue and the writeback stage(s).

Parameters:
- DATA_W, 32, register width in bits.
- NREGS, 32, number of registers; power of 2, >= 2. Localparam AW = $clog2(NREGS).
- NRD, 2, number of read ports, >= 1.
- NWR, 2, number of write ports, >= 1.
- ZERO_REG, 1, 1 = register 0 reads as 0, is never written, and is never busy.
- BYPASS, 1, 1 = read ports see same-cycle write data; 0 = reads return stored contents only.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- rsel  in  NRD*AW  read selects; port i uses bits [i*AW +: AW].
- rdat  out  NRD*DATA_W  read data; port i uses bits [i*DATA_W +: DATA_W].
- rbusy  out  NRD  busy flag of the register selected on each read port.
- wen  in  NWR  write enables.
- wsel  in  NWR*AW  write selects; port k uses bits [k*AW +: AW].
- wdat  in  NWR*DATA_W  write data.
- iss_en  in  1  issue strobe: mark iss_sel as having a pending write.
- iss_sel  in  AW  destination register of the issued instruction.
- wconflict  out  1  registered one-cycle pulse: two or more write ports targeted the same register in the previous cycle.

Behaviour:
- Reset: RST=1 at a rising edge clears every register to 0, every busy bit to 0, and wconflict to 0. RST dominates all writes and issues in that cycle; reset asserted mid-operation discards any in-flight writes or issues.
- Storage: NREGS x DATA_W flops plus NREGS busy flops. No other state except wconflict.
- Writes:
  - An enabled port k writes wdat_k to wsel_k at the rising edge.
  - With ZERO_REG=1, writes to register 0 are dropped.
  - If several enabled ports target the same register, the highest-index port wins.
- Reads: purely combinational, zero latency.
  - rdat_i = stored[rsel_i].
  - If BYPASS=1 and any enabled write port targets rsel_i this cycle, rdat_i = wdat of the highest-index such port.
  - With ZERO_REG=1, rsel_i=0 always returns 0 and rbusy_i=0, regardless of bypass.
- Busy scoreboard, evaluated per register each edge:
  - Set when iss_en=1 and iss_sel equals that register.
  - Else cleared when any enabled write port targets it.
  - Else held.
  - Issue has priority over a same-cycle write to the same register, i.e. a new producer is issued: the data is written but busy stays 1.
  - iss_sel=0 with ZERO_REG=1 is ignored.
- rbusy_i = busy[rsel_i]. If BYPASS=1 and an enabled write targets rsel_i this cycle, rbusy_i = 0 (data is available via bypass).
- wconflict: registered. It is 1 in cycle t+1 iff in cycle t at least two enabled write ports had equal wsel, excluding register 0 when ZERO_REG=1. It is 0 otherwise.
- No handshakes and no back-pressure: every write is accepted every cycle.
- Width rules:
  - No arithmetic on data.
  - Selects use the full AW bits.
  - When NREGS is a power of 2, out-of-range selects cannot occur.

Test Plan:
- Reset/zero (defaults): hold RST=1 two cycles, then read all 32 registers -> rdat=0, rbusy=0, wconflict=0. Write 0xDEADBEEF to reg0 on port 0, then read reg0 -> 0.
- Basic write/read:
  - Port0 writes reg5=0x11111111 and port1 writes reg9=0x22222222 in the same cycle; next cycle read 5 and 9 -> 0x11111111, 0x22222222.
  - With BYPASS=1, the same-cycle read of reg5 returns 0x11111111.
  - With BYPASS=0, the same-cycle read of reg5 returns the old value 0.
- Write collision: port0 writes reg7=0xAAAA0000 and port1 writes reg7=0x0000BBBB in the same cycle -> reg7=0x0000BBBB, wconflict=1 for exactly the following cycle, then 0. Both ports writing reg0 -> no wconflict.
- Scoreboard:
  - iss_en=1, iss_sel=12 -> next cycle rbusy=1 for reg12.
  - Port1 writes reg12=0x5 -> same-cycle rbusy=0 (BYPASS=1); following cycle busy=0.
  - Issue reg12 and write reg12=0x6 in the same cycle -> reg12=0x6 and busy stays 1.
- Reset mid-operation: with reg3 busy and a write of 0xFFFFFFFF to reg3 pending, assert RST in that cycle -> reg3=0 and busy=0 afterwards; the write is lost.
- Parameter sweep: DATA_W=16, NREGS=8, NRD=4, NWR=3, ZERO_REG=0 -> reg0 is writable (0x1234 reads back). Random writes/issues compared against a reference model for 10k cycles with no mismatches.
